// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode constants, state encoding,
// the registered control-output bundle and opcode classification helpers.
package alu_pkg;

    localparam int OPC_WIDTH = 5;

    typedef logic [OPC_WIDTH-1:0] opc_t;

    // Opcode map: 1..15 are legal, mul and div run on the iterative unit.
    localparam opc_t ADD = 5'd1;
    localparam opc_t SUB = 5'd2;
    localparam opc_t MUL = 5'd3;
    localparam opc_t DIV = 5'd4;
    localparam opc_t NOT = 5'd15;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_Y  = 3'd1,
        EXEC    = 3'd2,
        WAIT_MC = 3'd3,
        WRITE_Z = 3'd4,
        OUT_LO  = 3'd5,
        OUT_HI  = 3'd6
    } state_e;

    // Single-bit strobes driven by the sequencer, registered as one bundle.
    typedef struct packed {
        logic busy;
        logic yin;
        logic alu_start;
        logic zin;
        logic zlo_out;
        logic zhi_out;
        logic done;
        logic err;
    } ctl_t;

    function automatic logic is_multicycle(input opc_t opc);
        return (opc == MUL) || (opc == DIV);
    endfunction

    function automatic logic is_legal(input opc_t opc);
        return (opc != '0) && (opc <= NOT);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_mc_timer.sv
// Saturating wait timer for the mul/div handshake. 'clear' restarts it,
// 'en' advances it by one per cycle. 'expired' is high during the cycle whose
// increment brings the count to MAX, i.e. the last cycle the FSM may wait.
module mc_timer #(
    parameter int MAX = 40
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] LAST_V = W'(MAX - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and hold at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= LAST_V);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the Y -> ALU -> Z datapath. Steps yin, alu_op,
// zin, zlo_out and zhi_out for one operation at a time, drives the mul/div
// start/done handshake with a timeout, and reports done/err pulses.
// Optional statistics counters (op_cnt, err_cnt) exist only when the macro
// ALU_SEQ_STATS_EN is defined.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int MC_TIMEOUT = 40,
    parameter int OPC_W      = OPC_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    output logic             busy,
    output logic             yin,
    output logic [OPC_W-1:0] alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             zin,
    output logic             zlo_out,
    output logic             zhi_out,
    output logic             done,
    output logic             err
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]      op_cnt,
    output logic [7:0]       err_cnt
`endif
);

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic [OPC_W-1:0] alu_op_q, alu_op_d;
    ctl_t             ctl_q, ctl_d;
    logic             tmr_clear, tmr_en, tmr_expired;

    mc_timer #(
        .MAX (MC_TIMEOUT)
    ) u_mc_timer (
        .clk     (clk),
        .clr     (clr),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Next state plus the output values for that state, so outputs are
    // registered yet aligned with the state they belong to.
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        ctl_d     = '0;
        alu_op_d  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_legal(opcode)) begin
                        opc_d   = opcode;
                        state_d = LOAD_Y;
                    end else begin
                        ctl_d.err = 1'b1;
                    end
                end
            end
            LOAD_Y: state_d = EXEC;
            EXEC: begin
                if (is_multicycle(opc_q)) begin
                    tmr_clear = 1'b1;
                    state_d   = WAIT_MC;
                end else begin
                    state_d   = WRITE_Z;
                end
            end
            WAIT_MC: begin
                tmr_en = 1'b1;
                // A result arriving on the final allowed cycle still completes.
                if (alu_done) begin
                    state_d = WRITE_Z;
                end else if (tmr_expired) begin
                    ctl_d.err = 1'b1;
                    state_d   = IDLE;
                end
            end
            WRITE_Z: state_d = OUT_LO;
            OUT_LO:  state_d = is_multicycle(opc_q) ? OUT_HI : IDLE;
            OUT_HI:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ctl_d.busy      = (state_d != IDLE);
        ctl_d.yin       = (state_d == LOAD_Y);
        ctl_d.alu_start = (state_d == EXEC) && is_multicycle(opc_q);
        ctl_d.zin       = (state_d == WRITE_Z);
        ctl_d.zlo_out   = (state_d == OUT_LO);
        ctl_d.zhi_out   = (state_d == OUT_HI);
        ctl_d.done      = ((state_d == OUT_LO) && !is_multicycle(opc_q)) ||
                          (state_d == OUT_HI);
        if ((state_d == EXEC) || (state_d == WAIT_MC) || (state_d == WRITE_Z)) begin
            alu_op_d = opc_q;
        end
    end

    // State, latched opcode and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            opc_q    <= '0;
            alu_op_q <= '0;
            ctl_q    <= '0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            alu_op_q <= alu_op_d;
            ctl_q    <= ctl_d;
        end
    end

    assign busy      = ctl_q.busy;
    assign yin       = ctl_q.yin;
    assign alu_start = ctl_q.alu_start;
    assign zin       = ctl_q.zin;
    assign zlo_out   = ctl_q.zlo_out;
    assign zhi_out   = ctl_q.zhi_out;
    assign done      = ctl_q.done;
    assign err       = ctl_q.err;
    assign alu_op    = alu_op_q;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] op_cnt_q, op_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Saturating counters advanced together with the done/err pulses.
    always_comb begin
        op_cnt_d  = op_cnt_q;
        err_cnt_d = err_cnt_q;
        if (ctl_d.done && (op_cnt_q != 16'hFFFF)) begin
            op_cnt_d = op_cnt_q + 16'd1;
        end
        if (ctl_d.err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            op_cnt_q  <= op_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign op_cnt  = op_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: table of directed operations, an
// asynchronous clear in the middle of a mul, randomized operations with
// stray starts and stray alu_done, and the optional statistics counters.
module tb_alu_seq_ctrl;

    localparam int T = 40;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [4:0] opcode;
    logic       busy, yin, alu_start, alu_done, zin, zlo_out, zhi_out, done, err;
    logic [4:0] alu_op;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] op_cnt;
    logic [7:0]  err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    alu_seq_ctrl #(
        .MC_TIMEOUT (T),
        .OPC_W      (5)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .opcode    (opcode),
        .busy      (busy),
        .yin       (yin),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .zin       (zin),
        .zlo_out   (zlo_out),
        .zhi_out   (zhi_out),
        .done      (done),
        .err       (err)
`ifdef ALU_SEQ_STATS_EN
        ,
        .op_cnt    (op_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] pack_out();
        return {busy, yin, alu_start, zin, zlo_out, zhi_out, done, err, alu_op};
    endfunction

    // Expected outputs during cycle c (cycle 1 follows the accept edge),
    // when alu_done is driven high only during cycle k.
    function automatic logic [12:0] model(input logic [4:0] opc, input int k, input int c);
        bit b = 0, y = 0, st = 0, zi = 0, zl = 0, zh = 0, dn = 0, er = 0;
        logic [4:0] op = '0;
        bit hit;
        int w_end;
        if (opc == 0 || opc > 15) begin
            er = (c == 1);
        end else if (opc != 3 && opc != 4) begin
            b  = (c >= 1 && c <= 4);
            y  = (c == 1);
            op = (c >= 2 && c <= 3) ? opc : 5'd0;
            zi = (c == 3);
            zl = (c == 4);
            dn = (c == 4);
        end else begin
            hit   = (k >= 3 && k <= T + 2);
            w_end = hit ? k : T + 2;
            b  = (c >= 1 && c <= (hit ? k + 3 : w_end));
            y  = (c == 1);
            st = (c == 2);
            op = (c >= 2 && c <= (hit ? k + 1 : w_end)) ? opc : 5'd0;
            if (hit) begin
                zi = (c == k + 1);
                zl = (c == k + 2);
                zh = (c == k + 3);
                dn = (c == k + 3);
            end else begin
                er = (c == w_end + 1);
            end
        end
        return {b, y, st, zi, zl, zh, dn, er, op};
    endfunction

    // Issue one operation and check every output for each following cycle.
    // With stress set, start is pulsed while busy and alu_done is toggled
    // in cycles where the sequencer must ignore it.
    task automatic run_op(input logic [4:0] opc, input int k, input bit stress,
                          output int done_c, output int err_c);
        bit legal, mc, hit;
        int last, w_end;
        logic [12:0] exp;
        legal = (opc != 0) && (opc <= 15);
        mc    = legal && (opc == 3 || opc == 4);
        hit   = mc && k >= 3 && k <= T + 2;
        w_end = hit ? k : T + 2;
        last  = !legal ? 1 : (!mc ? 4 : (hit ? k + 3 : T + 3));
        done_c = 0;
        err_c  = 0;
        @(negedge clk);
        start    = 1'b1;
        opcode   = opc;
        alu_done = 1'b0;
        for (int c = 1; c <= last + 2; c++) begin
            @(negedge clk);
            exp = model(opc, k, c);
            check($sformatf("opc%0d k%0d cyc%0d", opc, k, c), 32'(pack_out()), 32'(exp));
            if (done) done_c = c;
            if (err)  err_c  = c;
            start    = stress && exp[12] && ($urandom_range(0, 1) == 1);
            opcode   = stress ? 5'($urandom_range(0, 31)) : opc;
            alu_done = (c == k) ||
                       (stress && (!mc || c < 3 || c > w_end) && ($urandom_range(0, 1) == 1));
        end
        start    = 1'b0;
        alu_done = 1'b0;
    endtask

    typedef struct {
        logic [4:0] opc;
        int         k;
        bit         stress;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int dc, ec;
        logic [4:0] ropc;
        int r;

        vecs[0]  = '{5'd1,  -1, 1'b0, 4,  0};
        vecs[1]  = '{5'd2,  -1, 1'b1, 4,  0};
        vecs[2]  = '{5'd15, -1, 1'b0, 4,  0};
        vecs[3]  = '{5'd3,  12, 1'b0, 15, 0};
        vecs[4]  = '{5'd4,  3,  1'b0, 6,  0};
        vecs[5]  = '{5'd4,  -1, 1'b0, 0,  43};
        vecs[6]  = '{5'd3,  42, 1'b0, 45, 0};
        vecs[7]  = '{5'd3,  43, 1'b0, 0,  43};
        vecs[8]  = '{5'd0,  -1, 1'b0, 0,  1};
        vecs[9]  = '{5'd16, -1, 1'b0, 0,  1};
        vecs[10] = '{5'd31, -1, 1'b0, 0,  1};
        vecs[11] = '{5'd3,  20, 1'b1, 23, 0};

        clr      = 1'b1;
        start    = 1'b0;
        opcode   = 5'd0;
        alu_done = 1'b0;
        #12;
        check("reset outputs", 32'(pack_out()), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].opc, vecs[i].k, vecs[i].stress, dc, ec);
            check($sformatf("vec%0d done cycle", i), 32'(dc), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d err cycle", i), 32'(ec), 32'(vecs[i].exp_err));
        end

        // Asynchronous clear in the middle of a mul wait.
        @(negedge clk);
        start  = 1'b1;
        opcode = 5'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("busy before clr", 32'(busy), 32'd1);
        #2 clr = 1'b1;
        #1 check("outputs right after clr", 32'(pack_out()), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        run_op(5'd1, -1, 1'b0, dc, ec);
        check("add after clr done cycle", 32'(dc), 32'd4);
        check("add after clr err cycle", 32'(ec), 32'd0);

        // Randomized operations with stray starts and stray alu_done.
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      ropc = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(16, 31)) : 5'd0;
            else if (r < 6) ropc = ($urandom_range(0, 1) == 1) ? 5'd3 : 5'd4;
            else            ropc = 5'($urandom_range(1, 15));
            run_op(ropc, $urandom_range(3, T + 5), 1'b1, dc, ec);
        end

`ifdef ALU_SEQ_STATS_EN
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("op_cnt after clr", 32'(op_cnt), 32'd0);
        run_op(5'd1, -1, 1'b0, dc, ec);
        run_op(5'd3, 5,  1'b0, dc, ec);
        run_op(5'd2, -1, 1'b0, dc, ec);
        run_op(5'd0, -1, 1'b0, dc, ec);
        check("op_cnt", 32'(op_cnt), 32'd3);
        check("err_cnt", 32'(err_cnt), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
